fxp_q512_result_packer: RTL and testbench
=========================================

// Module: fxp_q512_result_packer
// PURPOSE
//  Return path of the fixed-point datapath. Takes one beat of add/sub/mul results,
//  which are Q6.12 sums/differences and a Q10.24 product of two Q5.12 operands.
//  Rounds and saturates each result back to 17-bit Q3.14 for the output sample stream.
//  Sits downstream of add/subtract/mul; uses valid/ready handshakes on both sides.
// PARAMETERS
//  CNT_W     16  width of saturation-event counter (SAT_COUNT_EN only)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   input beat valid
//  in_ready   out  1   block accepts beat this cycle
//  in_add     in   18  sum, Q6.12 two's complement
//  in_sub     in   18  difference, Q6.12
//  in_mul     in   34  product, Q10.24
//  out_valid  out  1   output beat valid
//  out_ready  in   1   downstream accepts beat
//  out_add    out  17  Q3.14
//  out_sub    out  17  Q3.14
//  out_mul    out  17  Q3.14
//  out_sat    out  3   per-channel saturation flag {mul,sub,add} for this beat
//  sat_cnt    out  CNT_W  count of output beats with any out_sat bit set
//  cnt_clr    in   1   synchronous clear of sat_cnt
// BEHAVIOUR
//  - Reset: out_valid=0, out_add/sub/mul=0, out_sat=0, sat_cnt=0.
//    in_ready=1 in the first cycle after reset.
//  - Transfer on each side when valid&&ready.
//    Beat data must stay stable while out_valid=1 and out_ready=0.
//  - 2-stage pipeline: S1 registers the rounded values, S2 registers the saturated values and flags.
//    Latency is 2 cycles from input transfer to out_valid when out_ready=1. Throughput is 1 beat/cycle.
//  - Stage advance: S2 loads when S2 is empty or out_ready=1. S1 loads when S1 is empty or S1 advances.
//    in_ready = !s1_valid || s1_advance.
//    No beat is lost, duplicated or reordered under any out_ready pattern.
//  - add/sub: shift left 2 ({x,2'b00}, 20 bits); no rounding needed.
//    Clamp to [17'h10000, 17'h0FFFF], i.e. [-4.0, +3.99994]; set flag if clamped.
//  - mul: add 34'h200 (round half up, matching the Q3.14->Q5.12 converter).
//    Then take bits [33:10] (24-bit Q10.14) and clamp to 17 bits as above.
//    The rounding add is done in 35 bits and never wraps.
//  - Clamp rule: value > 0x0FFFF gives 0x0FFFF; value < -0x10000 gives 0x10000. Exact extremes are not flagged.
//  - sat_cnt increments on an output transfer with |out_sat.
//    It stops at all-ones and does not wrap.
//    If cnt_clr and an increment occur in the same cycle, the result is 0 (clear wins).
//  - rst mid-operation discards both stages; the next cycle is identical to post-reset.
// CONFIGURATION
//  - FXP_SAT_COUNT_EN defined: sat_cnt counter built as above.
//  - Undefined: no counter logic; sat_cnt tied to 0, cnt_clr ignored. Ports unchanged.
// STRUCTURE
//  - Package fxp_pkg: Q5.12/Q3.14/Q6.12/Q10.24 widths and frac-bit constants.
//    Also Q314_MAX=17'h0FFFF, Q314_MIN=17'h10000, MUL_RND=34'h200.
//  - Sub-module fxp_round_sat #(IN_W, DROP, OUT_W) does round-half-up, drop and clamp.
//    It outputs a value and a sat flag, with the rounding step registered internally.
//    Instantiated 3x: add/sub with DROP=0 on the pre-shifted input, mul with DROP=10.
// TESTING
//  1. in_add=18'h01000 (1.0), out_ready=1 -> 2 cycles later out_add=17'h04000, out_sat=0.
//  2. in_add=18'h08000 (8.0) and in_sub=18'h38000 (-8.0)
//     -> out_add=17'h0FFFF, out_sub=17'h10000, out_sat=3'b011.
//  3. in_mul=34'h002400000 (1.5*1.5) -> out_mul=17'h09000 (2.25), out_sat[2]=0.
//  4. Rounding on the mul channel:
//     34'h200 -> 17'h00001; 34'h1FF -> 0; 34'h3FFFFFE00 (-0.5 LSB) -> 0.
//  5. Stream 10 beats with out_ready low for cycles 3-7.
//     -> in_ready drops after 2 beats are held; output order and count match input exactly.
//  6. With FXP_SAT_COUNT_EN: 3 saturating beats -> sat_cnt=3.
//     cnt_clr together with a saturating beat -> 0.
//     rst with a full pipeline -> next cycle out_valid=0, in_ready=1, sat_cnt=0.

Source files
------------

// File: rtl/fxp_pkg.sv
// Fixed-point format constants shared by the result packer and its
// round/saturate slices.
package fxp_pkg;

    localparam int Q512_W     = 17;
    localparam int Q512_FRAC  = 12;
    localparam int Q314_W     = 17;
    localparam int Q314_FRAC  = 14;
    localparam int Q612_W     = 18;
    localparam int Q612_FRAC  = 12;
    localparam int Q1024_W    = 34;
    localparam int Q1024_FRAC = 24;

    // add/sub gain fraction bits by a plain left shift; mul drops LSBs
    localparam int ADDSUB_SHIFT = Q314_FRAC - Q612_FRAC;
    localparam int MUL_DROP     = Q1024_FRAC - Q314_FRAC;

    localparam logic [Q314_W-1:0]  Q314_MAX = 17'h0FFFF;
    localparam logic [Q314_W-1:0]  Q314_MIN = 17'h10000;
    localparam logic [Q1024_W-1:0] MUL_RND  = 34'h200;

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-up, drop DROP LSBs and clamp to a signed OUT_W result.
// The rounded value is registered (pipeline stage 1); the clamp and the
// saturation flag are combinational from that register.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int DROP  = 0,
    parameter int OUT_W = Q314_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    // Half an output LSB; zero when nothing is dropped. One guard bit keeps the add from wrapping.
    localparam logic signed [IN_W:0] RND    = ((IN_W+1)'(1) << DROP) >> 1;
    localparam logic signed [IN_W:0] SAT_HI = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_LO = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] rnd_q;

    // Sign-extend by one bit and add the rounding constant
    always_comb begin
        sum = $signed({din[IN_W-1], din}) + RND;
    end

    // Stage 1: hold the rounded, LSB-dropped value
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q <= '0;
        end else if (load) begin
            rnd_q <= sum >>> DROP;
        end
    end

    // Clamp to the signed output range; exact extremes pass unflagged
    always_comb begin
        dout = rnd_q[OUT_W-1:0];
        sat  = 1'b0;
        if (rnd_q > SAT_HI) begin
            dout = SAT_HI[OUT_W-1:0];
            sat  = 1'b1;
        end else if (rnd_q < SAT_LO) begin
            dout = SAT_LO[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_q512_result_packer.sv
// Return path of the fixed-point datapath: converts one beat of
// add/sub (Q6.12) and mul (Q10.24) results to saturated Q3.14 through a
// two-stage valid/ready pipeline.
// Build option: FXP_SAT_COUNT_EN adds the saturation-event counter on
// sat_cnt; without it sat_cnt reads 0 and cnt_clr is ignored.
module fxp_q512_result_packer
    import fxp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q612_W-1:0]  in_add,
    input  logic [Q612_W-1:0]  in_sub,
    input  logic [Q1024_W-1:0] in_mul,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q314_W-1:0]  out_add,
    output logic [Q314_W-1:0]  out_sub,
    output logic [Q314_W-1:0]  out_mul,
    output logic [2:0]         out_sat,
    output logic [CNT_W-1:0]   sat_cnt,
    input  logic               cnt_clr
);

    localparam int ADDSUB_W = Q612_W + ADDSUB_SHIFT;

    logic                s1_valid;
    logic                s1_load;
    logic                s1_advance;
    logic                s2_load;
    logic [ADDSUB_W-1:0] add_sh;
    logic [ADDSUB_W-1:0] sub_sh;
    logic [Q314_W-1:0]   add_val, sub_val, mul_val;
    logic                add_sat, sub_sat, mul_sat;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign s1_load    = in_valid && in_ready;

    assign add_sh = {in_add, {ADDSUB_SHIFT{1'b0}}};
    assign sub_sh = {in_sub, {ADDSUB_SHIFT{1'b0}}};

    fxp_round_sat #(.IN_W(ADDSUB_W), .DROP(0), .OUT_W(Q314_W)) u_add (
        .clk(clk), .rst(rst), .load(s1_load), .din(add_sh), .dout(add_val), .sat(add_sat)
    );

    fxp_round_sat #(.IN_W(ADDSUB_W), .DROP(0), .OUT_W(Q314_W)) u_sub (
        .clk(clk), .rst(rst), .load(s1_load), .din(sub_sh), .dout(sub_val), .sat(sub_sat)
    );

    fxp_round_sat #(.IN_W(Q1024_W), .DROP(MUL_DROP), .OUT_W(Q314_W)) u_mul (
        .clk(clk), .rst(rst), .load(s1_load), .din(in_mul), .dout(mul_val), .sat(mul_sat)
    );

    // Stage 1 occupancy: filled on input transfer, emptied when it moves to stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: registered saturated results; held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_add   <= '0;
            out_sub   <= '0;
            out_mul   <= '0;
            out_sat   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_add <= add_val;
                out_sub <= sub_val;
                out_mul <= mul_val;
                out_sat <= {mul_sat, sub_sat, add_sat};
            end
        end
    end

`ifdef FXP_SAT_COUNT_EN
    // Count delivered beats that saturated any channel; sticks at all-ones, clear wins
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && (|out_sat) && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fxp_q512_result_packer.sv
// Self-checking bench for fxp_q512_result_packer: table vectors, stall,
// reset and counter sequences, and a random stream under random backpressure.
module tb_fxp_q512_result_packer;

`ifdef FXP_SAT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [16:0] a;
        logic [16:0] s;
        logic [16:0] m;
        logic [2:0]  sat;
    } exp_t;

    typedef struct packed {
        logic [17:0] a;
        logic [17:0] s;
        logic [33:0] m;
        logic [16:0] ea;
        logic [16:0] es;
        logic [16:0] em;
        logic [2:0]  esat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_add = '0;
    logic [17:0] in_sub = '0;
    logic [33:0] in_mul = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_add, out_sub, out_mul;
    logic [2:0]  out_sat;
    logic [15:0] sat_cnt;
    logic        cnt_clr = 1'b0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    exp_t sb[$];
    logic [15:0] exp_cnt = '0;
    exp_t m_e;
    bit   m_x;
    bit   stop_bp;
    vec_t vt[13];

    fxp_q512_result_packer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_add(in_add), .in_sub(in_sub), .in_mul(in_mul),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_add(out_add), .out_sub(out_sub), .out_mul(out_mul),
        .out_sat(out_sat), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] clamp(input longint v, output bit s);
        s = 1'b0;
        if (v > 65535) begin
            s = 1'b1;
            return 17'h0FFFF;
        end
        if (v < -65536) begin
            s = 1'b1;
            return 17'h10000;
        end
        return 17'(v);
    endfunction

    function automatic exp_t model(input logic [17:0] a, input logic [17:0] s, input logic [33:0] m);
        exp_t e;
        bit   sa, ss, sm;
        e.a   = clamp(longint'($signed(a)) * 4, sa);
        e.s   = clamp(longint'($signed(s)) * 4, ss);
        e.m   = clamp((longint'($signed(m)) + 512) >>> 10, sm);
        e.sat = {sm, ss, sa};
        return e;
    endfunction

    // Offer one beat starting at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send(input logic [17:0] a, input logic [17:0] s, input logic [33:0] m, input exp_t e);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_add   = a;
        in_sub   = s;
        in_mul   = m;
        n   = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            sb.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(nm, sb.size(), 0);
    endtask

    // Output monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt = '0;
        end else begin
            chk("sat_cnt_track", sat_cnt, exp_cnt);
            m_x = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got add=%h sub=%h mul=%h, expected no beat", out_add, out_sub, out_mul);
                end else begin
                    m_e = sb.pop_front();
                    chk("out_add", out_add, m_e.a);
                    chk("out_sub", out_sub, m_e.s);
                    chk("out_mul", out_mul, m_e.m);
                    chk("out_sat", out_sat, m_e.sat);
                    m_x = |m_e.sat;
                end
            end
            if (CNT_EN) begin
                if (cnt_clr) exp_cnt = '0;
                else if (m_x && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        exp_t e;
        int   base;
        int   n;
        logic [63:0] r;
        logic [17:0] ra, rs;
        logic [33:0] rm;

        vt[0]  = '{18'h01000, 18'h00000, 34'h000000000, 17'h04000, 17'h00000, 17'h00000, 3'b000};
        vt[1]  = '{18'h08000, 18'h38000, 34'h000000000, 17'h0FFFF, 17'h10000, 17'h00000, 3'b011};
        vt[2]  = '{18'h00000, 18'h00000, 34'h002400000, 17'h00000, 17'h00000, 17'h09000, 3'b000};
        vt[3]  = '{18'h00000, 18'h00000, 34'h000000200, 17'h00000, 17'h00000, 17'h00001, 3'b000};
        vt[4]  = '{18'h00000, 18'h00000, 34'h0000001FF, 17'h00000, 17'h00000, 17'h00000, 3'b000};
        vt[5]  = '{18'h00000, 18'h00000, 34'h3FFFFFE00, 17'h00000, 17'h00000, 17'h00000, 3'b000};
        vt[6]  = '{18'h03FFF, 18'h3C000, 34'h003FFFC00, 17'h0FFFC, 17'h10000, 17'h0FFFF, 3'b000};
        vt[7]  = '{18'h04000, 18'h3BFFF, 34'h003FFFE00, 17'h0FFFF, 17'h10000, 17'h0FFFF, 3'b111};
        vt[8]  = '{18'h20000, 18'h1FFFF, 34'h200000000, 17'h10000, 17'h0FFFF, 17'h10000, 3'b111};
        vt[9]  = '{18'h00000, 18'h00000, 34'h1FFFFFFFF, 17'h00000, 17'h00000, 17'h0FFFF, 3'b100};
        vt[10] = '{18'h00000, 18'h00000, 34'h3FC000000, 17'h00000, 17'h00000, 17'h10000, 3'b000};
        vt[11] = '{18'h00000, 18'h00000, 34'h3FBFFFE00, 17'h00000, 17'h00000, 17'h10000, 3'b000};
        vt[12] = '{18'h00000, 18'h00000, 34'h3FBFFFDFF, 17'h00000, 17'h00000, 17'h10000, 3'b100};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_add", out_add, 0);
        chk("rst_out_sub", out_sub, 0);
        chk("rst_out_mul", out_mul, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);

        // Latency: first beat appears two edges after its transfer
        send(vt[0].a, vt[0].s, vt[0].m, '{vt[0].ea, vt[0].es, vt[0].em, vt[0].esat});
        chk("lat_1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_2_out_valid", out_valid, 1);
        drain("drain_latency");

        // Table vectors, back to back
        for (int i = 0; i < 13; i++) begin
            send(vt[i].a, vt[i].s, vt[i].m, '{vt[i].ea, vt[i].es, vt[i].em, vt[i].esat});
        end
        drain("drain_table");

        // 10-beat stream with downstream stalled for cycles 3-7
        base = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = 18'(i * 18'h00321 + 18'h00100);
                    rs = 18'h3F000 - 18'(i * 18'h00155);
                    rm = 34'(i) * 34'h000123400;
                    send(ra, rs, rm, model(ra, rs, rm));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stream");
        chk("stream_count", n_out - base, 10);

        // Counter: clear, then three saturating beats
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(vt[7].a, vt[7].s, vt[7].m, '{vt[7].ea, vt[7].es, vt[7].em, vt[7].esat});
        end
        drain("drain_cnt");
        chk("sat_cnt_3", sat_cnt, CNT_EN ? 3 : 0);

        // Clear coinciding with a saturating output transfer
        out_ready = 1'b0;
        send(vt[1].a, vt[1].s, vt[1].m, '{vt[1].ea, vt[1].es, vt[1].em, vt[1].esat});
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clr_wait_valid", out_valid, 1);
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("sat_cnt_clr_wins", sat_cnt, 0);
        drain("drain_clr");

        // Build up a count, fill the pipeline, then reset
        send(vt[8].a, vt[8].s, vt[8].m, '{vt[8].ea, vt[8].es, vt[8].em, vt[8].esat});
        drain("drain_pre_rst");
        out_ready = 1'b0;
        send(vt[7].a, vt[7].s, vt[7].m, '{vt[7].ea, vt[7].es, vt[7].em, vt[7].esat});
        send(vt[1].a, vt[1].s, vt[1].m, '{vt[1].ea, vt[1].es, vt[1].em, vt[1].esat});
        chk("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sat_cnt", sat_cnt, 0);
        chk("midrst_out_sat", out_sat, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_ghost", out_valid, 0);

        // Random stream under random backpressure
        stop_bp = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r  = {$urandom, $urandom};
                    ra = r[63] ? r[17:0] : {{3{r[14]}}, r[14:0]};
                    rs = r[62] ? r[35:18] : {{3{r[32]}}, r[32:18]};
                    r  = {$urandom, $urandom};
                    rm = r[63] ? r[33:0] : {{8{r[25]}}, r[25:0]};
                    send(ra, rs, rm, model(ra, rs, rm));
                end
                stop_bp = 1'b1;
            end
            begin
                while (!stop_bp) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");
        chk("random_count", n_out - base, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
